// File: rtl/abro_multi_fsm.sv
//------------------------------------------------------------------------------
// abro_multi_fsm
//   N-input await-all/emit/restart controller with sticky arrival mask,
//   saturating completion counter and optional wait timeout
//   (enabled by defining ABRO_MULTI_TIMEOUT_EN).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module abro_multi_fsm #(
  parameter int N       = 2,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r,
  input  logic [N-1:0]     in,
  output logic             o,
  output logic [N-1:0]     seen,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] done_count,
  output logic             timeout
);

  typedef enum logic [1:0] {
    S_WAIT    = 2'b00,
    S_HOLD    = 2'b01,
    S_EXPIRED = 2'b10,
    S_UNUSED  = 2'b11
  } state_e;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("abro_multi_fsm: TIMEOUT must be >= 2");
  end

  state_e           state_q, state_d;
  logic [N-1:0]     seen_q, seen_d;
  logic             o_q, o_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_d;
  logic [N-1:0]     w_merged;
  logic             w_all;

  assign w_merged = seen_q | in;
  assign w_all    = &w_merged;

`ifdef ABRO_MULTI_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             to_q;
`endif

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    o_d     = 1'b0;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
`ifdef ABRO_MULTI_TIMEOUT_EN
    timer_d = timer_q;
`endif
    case (state_q)
      S_WAIT: begin
        if (r) begin
          // Restart outranks a completion arriving on the same edge.
          seen_d = '0;
`ifdef ABRO_MULTI_TIMEOUT_EN
          timer_d = '0;
`endif
        end else if (w_all) begin
          state_d = S_HOLD;
          o_d     = 1'b1;
          seen_d  = '0;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
`ifdef ABRO_MULTI_TIMEOUT_EN
          timer_d = '0;
`endif
        end else begin
          seen_d = w_merged;
`ifdef ABRO_MULTI_TIMEOUT_EN
          if (seen_q != '0) begin
            if (timer_q == TMR_W'(TIMEOUT - 1)) begin
              state_d = S_EXPIRED;
              to_d    = 1'b1;
              seen_d  = '0;
              timer_d = '0;
            end else begin
              timer_d = timer_q + TMR_W'(1);
            end
          end
`endif
        end
      end
      S_HOLD, S_EXPIRED: begin
        seen_d = '0;
        if (r) begin
          state_d = S_WAIT;
`ifdef ABRO_MULTI_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      default: begin
        state_d = S_WAIT;
        seen_d  = '0;
`ifdef ABRO_MULTI_TIMEOUT_EN
        timer_d = '0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      seen_q  <= '0;
      o_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ABRO_MULTI_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      to_q    <= 1'b0;
    end else begin
      timer_q <= timer_d;
      to_q    <= to_d;
    end
  end
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign o          = o_q;
  assign seen       = seen_q;
  assign state      = state_q;
  assign done_count = cnt_q;

endmodule

`default_nettype wire

// File: doc/abro_multi_fsm.md
# abro_multi_fsm

Parametrised N-input ABRO ("await all, emit, restart") controller. It latches one-shot arrivals on N event inputs, emits a single-cycle `o` pulse once every channel has been seen, then holds until a restart request. It adds per-channel arrival visibility, a saturating completion counter and an optional wait timeout. It replaces the fixed two-input A/B state machine in the control path.

## Interface
- `N`, 2: number of event channels (N ≥ 1).
- `CNT_W`, 8: width of the completion counter.
- `TIMEOUT`, 16: cycles allowed between first arrival and completion (≥ 2). Used only when `ABRO_MULTI_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `r`  in  1  synchronous restart request.
- `in`  in  N  event inputs, sampled each edge; level-high counts as arrival.
- `o`  out  1  registered one-cycle completion pulse.
- `seen`  out  N  registered arrival mask for the current round.
- `state`  out  2  current state encoding.
- `done_count`  out  CNT_W  saturating count of completed rounds.
- `timeout`  out  1  registered one-cycle timeout pulse. Driven 0 when the macro is not defined.

## Operation
- States: WAIT=2'b00, HOLD=2'b01, EXPIRED=2'b10. Encoding 2'b11 is unused; if reached, the next edge forces WAIT and clears `seen`.
- Reset values: `state`=WAIT, `seen`=0, `o`=0, `timeout`=0, `done_count`=0, internal timer=0.
- WAIT:
  - `seen <= seen | in` each edge.
  - If `(seen | in)` is all-ones: go to HOLD, `o<=1` for one cycle, `seen<=0`, and `done_count` increments. Saturate at 2^CNT_W−1.
- HOLD: `in` is ignored and `seen` stays 0. When `r`=1, go to WAIT.
- EXPIRED (macro only): same as HOLD. `r` returns to WAIT.
- `r`=1 in WAIT: `seen<=0`, stay in WAIT, timer cleared. `r` has priority over completion in the same cycle: no `o` pulse and no count increment.
- `o` and `timeout` are 0 in every cycle except their single pulse cycle.
- Arrivals are sticky. An input that drops after being seen stays recorded.
- Repeated assertion of an already-seen channel has no effect.
- An all-ones `in` in a single WAIT cycle completes immediately.
- `done_count` is cleared only by `reset`, never by `r`.

## Timing
- Completing sample at edge k: `o`=1 and `state`=HOLD from edge k to edge k+1; `o`=0 after edge k+1.
- `r` sampled in HOLD at edge k: `state`=WAIT after edge k. The earliest next completion sample is edge k+1.
- Asynchronous `reset` mid-round: immediate return to reset values. Any in-flight `o`/`timeout` pulse is cut.
- Deassertion of `reset` is synchronised externally. The first active edge after release behaves as WAIT with an empty mask.
- Throughput: at most one completion per two cycles (completion edge plus one restart edge).

## Configuration
- Macro: `ABRO_MULTI_TIMEOUT_EN`.
- Defined:
  - The timer, `$clog2(TIMEOUT+1)` bits, counts WAIT cycles while `seen`≠0. It is cleared on entry to WAIT, on `r`, and on completion.
  - When the timer equals TIMEOUT−1 and the current edge is neither a completion nor an `r`: go to EXPIRED, `timeout<=1` for one cycle, `seen<=0`.
  - Completion in the same cycle as expiry wins: the block takes the `o` path, not the timeout.
- Not defined: no timer, EXPIRED is unreachable, and `timeout` is tied to 0.

## Test plan
- N=3, `in`=001, 100, 010 on three consecutive edges:
  - `seen` steps 001→101.
  - Third edge: `o`=1 for one cycle, `state`=01, `seen`=000, `done_count`=1.
  - Further `in` activity is ignored until `r`.
- N=3, `in`=111 in one WAIT cycle: `o` pulses on that edge. Then `r`=1 for one cycle, and `in`=111 again gives a second pulse with `done_count`=2.
- N=2: `seen`=01 and `in`=10 with `r`=1 on the same edge: no `o`, `seen`=00, `state`=00, `done_count` unchanged.
- CNT_W=2, five completed rounds: `done_count` reads 1, 2, 3, 3, 3. `o` pulses all five times.
- Reset mid-round: `seen`=01, assert `reset` between edges. `seen`, `o`, `state` and `done_count` go to 0 immediately, without waiting for a clock edge.
- Macro defined, TIMEOUT=4, N=2, `in`=01 once then 00:
  - `timeout`=1 on the 4th edge after the first arrival, `state`=10, `seen`=00.
  - `in`=11 is ignored until `r`.
  - Repeat with `in`=10 on that 4th edge: `o` pulses and `timeout` stays 0.
